// File: rtl/im_load_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | im_load_pkg : shared state encoding and default widths for im_load_*  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package im_load_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 32;
  localparam int c_DEFAULT_ADDR_WIDTH = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/im_load_cksum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | im_load_cksum : running modulo-2**DATA_WIDTH sum of written words     |
// | Present only when IM_LOAD_CKSUM_EN is defined.  Rev 1.0               |
// +----------------------------------------------------------------------+
`ifdef IM_LOAD_CKSUM_EN
module im_load_cksum
  import im_load_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_data,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_sum <= '0;
    else if (clear)  r_sum <= '0;
    else if (add_en) r_sum <= r_sum + add_data;
  end

  assign sum = r_sum;

endmodule
`endif
`default_nettype wire

// File: rtl/im_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | im_load_ctrl : copies a word block from a source port into IM, with   |
// | optional offset commit; checksum enabled by IM_LOAD_CKSUM_EN. Rev 1.0 |
// +----------------------------------------------------------------------+
module im_load_ctrl
  import im_load_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  commit_en,
  input  logic [DATA_WIDTH-1:0] src_base,
  input  logic [DATA_WIDTH-1:0] dst_base,
  input  logic [DATA_WIDTH-1:0] length,
  output logic                  src_req,
  output logic [DATA_WIDTH-1:0] src_addr,
  input  logic                  src_ack,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  im_write,
  output logic [DATA_WIDTH-1:0] im_write_addr,
  output logic [DATA_WIDTH-1:0] im_write_data,
  output logic [DATA_WIDTH-1:0] im_offset,
  output logic                  flag_imoffset,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [DATA_WIDTH:0]   c_IM_DEPTH = {{DATA_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] c_ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_src_base, r_dst_base, r_length, r_index, r_word, r_im_offset;
  logic                  r_commit_en, r_err;
  logic                  w_range_bad, w_accept, w_last;

  // Extra bit keeps dst_base+length from wrapping back into range
  assign w_range_bad = ({1'b0, dst_base} + {1'b0, length}) > c_IM_DEPTH;
  assign w_accept    = (r_state == IDLE) && start && !abort && !w_range_bad;
  assign w_last      = (r_index == (r_length - c_ONE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    src_req       = 1'b0;
    src_addr      = '0;
    im_write      = 1'b0;
    im_write_addr = '0;
    im_write_data = '0;
    flag_imoffset = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = (length == '0) ? DONE : READ;
      end
      READ: begin
        src_req  = 1'b1;
        src_addr = r_src_base + r_index;
        if (abort)        w_next = IDLE;
        else if (src_ack) w_next = WRITE;
      end
      WRITE: begin
        if (abort) w_next = IDLE;
        else begin
          im_write      = 1'b1;
          im_write_addr = r_dst_base + r_index;
          im_write_data = r_word;
          if (w_last) w_next = r_commit_en ? COMMIT : DONE;
          else        w_next = READ;
        end
      end
      COMMIT: begin
        if (abort) w_next = IDLE;
        else begin
          flag_imoffset = 1'b1;
          w_next        = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
        if (!abort) done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_length    <= '0;
      r_commit_en <= 1'b0;
      r_index     <= '0;
      r_word      <= '0;
    end else begin
      if (w_accept) begin
        r_src_base  <= src_base;
        r_dst_base  <= dst_base;
        r_length    <= length;
        r_commit_en <= commit_en;
        r_index     <= '0;
      end
      if (r_state == READ && src_ack && !abort) r_word <= src_data;
      if (im_write) r_index <= r_index + c_ONE;
    end
  end

  // Offset register only changes on an un-aborted COMMIT cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_im_offset <= '0;
      r_err       <= 1'b0;
    end else begin
      if (flag_imoffset) r_im_offset <= r_dst_base;
      r_err <= ((r_state != IDLE) && abort) ||
               ((r_state == IDLE) && start && !abort && w_range_bad);
    end
  end

  assign im_offset = flag_imoffset ? r_dst_base : r_im_offset;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

`ifdef IM_LOAD_CKSUM_EN
  im_load_cksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cksum (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_accept),
    .add_en   (im_write),
    .add_data (r_word),
    .sum      (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_im_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_im_load_ctrl : scoreboard bench for im_load_ctrl  Rev 1.0          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_im_load_ctrl;

`ifdef IM_LOAD_CKSUM_EN
  localparam bit c_CKSUM = 1'b1;
`else
  localparam bit c_CKSUM = 1'b0;
`endif

  logic        clock, reset, start, abort, commit_en;
  logic [31:0] src_base, dst_base, length;
  logic        src_req, src_ack, im_write, flag_imoffset, busy, done, err;
  logic [31:0] src_addr, src_data, im_write_addr, im_write_data, im_offset, checksum;

  im_load_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .commit_en(commit_en),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
    .im_write(im_write), .im_write_addr(im_write_addr), .im_write_data(im_write_data),
    .im_offset(im_offset), .flag_imoffset(flag_imoffset), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int busy_seen, req_seen, err_cnt, done_cnt, wr_cnt, flag_cnt, extra_wr, extra_flag;
  int ack_delay = 0, req_cycles = 0;
  logic [31:0] held_addr, exp_sum;
  logic [31:0] src_mem [1024];
  logic [31:0] exp_addr_q[$], exp_data_q[$], exp_off_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clock) cyc++;

  // Source responder: acks after ack_delay wait cycles, checks request stability
  always @(negedge clock) begin
    if (src_req) begin
      if (req_cycles == 0) held_addr = src_addr;
      else check("src_addr_hold", src_addr, held_addr);
      if (req_cycles >= ack_delay) begin
        src_ack    = 1'b1;
        src_data   = src_mem[src_addr[9:0]];
        req_cycles = 0;
      end else begin
        src_ack = 1'b0;
        req_cycles++;
      end
    end else begin
      src_ack    = 1'b0;
      req_cycles = 0;
    end
  end

  // Output monitor: scoreboard pops for writes and offset strobes
  always @(negedge clock) begin
    if (busy)    busy_seen++;
    if (src_req) req_seen++;
    if (err)     err_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (im_write) begin
      wr_cnt++;
      if (exp_addr_q.size() == 0) extra_wr++;
      else begin
        check("im_write_addr", im_write_addr, exp_addr_q.pop_front());
        check("im_write_data", im_write_data, exp_data_q.pop_front());
      end
    end
    if (flag_imoffset) begin
      flag_cnt++;
      if (exp_off_q.size() == 0) extra_flag++;
      else check("im_offset_strobe", im_offset, exp_off_q.pop_front());
    end
  end

  task automatic clr_stats();
    busy_seen = 0; req_seen = 0; err_cnt = 0; done_cnt = 0;
    wr_cnt = 0; flag_cnt = 0; extra_wr = 0; extra_flag = 0;
  endtask

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                       input logic c, input int n_exp, input bit off_exp);
    @(posedge clock); #1;
    start_cyc = cyc;
    src_base = s; dst_base = d; length = n; commit_en = c; start = 1'b1;
    exp_sum = '0;
    for (int i = 0; i < n_exp; i++) begin
      logic [31:0] a;
      a = s + 32'(i);
      exp_addr_q.push_back(d + 32'(i));
      exp_data_q.push_back(src_mem[a[9:0]]);
      exp_sum = exp_sum + src_mem[a[9:0]];
    end
    if (off_exp) exp_off_q.push_back(d);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && err_cnt == 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_timeout"}, 32'(k >= budget), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_pending"}, 32'(exp_addr_q.size() + exp_off_q.size()), 32'd0);
    check({tag, "_extra"}, 32'(extra_wr + extra_flag), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0; start = 1'b0; abort = 1'b0; commit_en = 1'b0;
    src_base = '0; dst_base = '0; length = '0; src_ack = 1'b0; src_data = '0;
    for (int i = 0; i < 1024; i++) src_mem[i] = {16'h5A00 + 16'(i), 16'(i) ^ 16'hFFFF};
    clr_stats();
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_src_req", 32'(src_req), 0);
    check("rst_im_write", 32'(im_write), 0);
    check("rst_outputs", 32'({done, err, flag_imoffset}), 0);
    check("rst_im_offset", im_offset, 0);
    check("rst_checksum", checksum, 0);
    reset = 1'b1;

    // Basic 3-word load with commit
    src_mem[10'h100] = 32'hA000_0001; src_mem[10'h101] = 32'hB000_0002; src_mem[10'h102] = 32'hC000_0003;
    clr_stats(); ack_delay = 0;
    issue(32'h100, 32'h40, 32'd3, 1'b1, 3, 1'b1);
    wait_end("basic", 50);
    check("basic_latency", 32'(done_cyc - start_cyc), 32'd8);
    check("basic_writes", 32'(wr_cnt), 32'd3);
    check("basic_flag", 32'(flag_cnt), 32'd1);
    check("basic_done", 32'(done_cnt), 32'd1);
    check("basic_im_offset", im_offset, 32'h40);
    check("basic_checksum", checksum, c_CKSUM ? exp_sum : 32'd0);
    end_checks("basic");

    // Two words, no commit: offset keeps previous value
    clr_stats();
    issue(32'h104, 32'h80, 32'd2, 1'b0, 2, 1'b0);
    wait_end("nocommit", 50);
    check("nocommit_latency", 32'(done_cyc - start_cyc), 32'd5);
    check("nocommit_flag", 32'(flag_cnt), 32'd0);
    check("nocommit_im_offset", im_offset, 32'h40);
    end_checks("nocommit");

    // Zero length: straight to DONE
    clr_stats();
    issue(32'h0, 32'h10, 32'd0, 1'b1, 0, 1'b0);
    wait_end("len0", 20);
    check("len0_latency", 32'(done_cyc - start_cyc), 32'd1);
    check("len0_src_req", 32'(req_seen), 32'd0);
    check("len0_writes", 32'(wr_cnt + flag_cnt), 32'd0);
    check("len0_checksum", checksum, 32'd0);
    end_checks("len0");

    // Range overflow rejected, exact-fit boundary accepted
    clr_stats();
    issue(32'h108, 32'h3FFE, 32'd3, 1'b1, 0, 1'b0);
    wait_end("range", 20);
    check("range_err", 32'(err_cnt), 32'd1);
    check("range_busy_seen", 32'(busy_seen), 32'd0);
    check("range_activity", 32'(wr_cnt + req_seen + done_cnt), 32'd0);
    end_checks("range");
    clr_stats();
    issue(32'h110, 32'h3FFD, 32'd3, 1'b0, 3, 1'b0);
    wait_end("edge", 50);
    check("edge_err", 32'(err_cnt), 32'd0);
    check("edge_latency", 32'(done_cyc - start_cyc), 32'd7);
    end_checks("edge");

    // Slow source plus a start pulse while busy
    clr_stats(); ack_delay = 5;
    issue(32'h120, 32'h300, 32'd2, 1'b0, 2, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1; src_base = 32'h200; dst_base = 32'h500; length = 32'd1; commit_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_end("slow", 100);
    check("slow_writes", 32'(wr_cnt), 32'd2);
    check("slow_latency", 32'(done_cyc - start_cyc), 32'd15);
    check("slow_flag", 32'(flag_cnt), 32'd0);
    end_checks("slow");

    // Abort during the second READ of a 4-word load
    clr_stats(); ack_delay = 3;
    issue(32'h130, 32'h600, 32'd4, 1'b1, 1, 1'b0);
    k = 0;
    while (!(wr_cnt == 1 && src_req) && k < 100) begin @(negedge clock); k++; end
    check("abort_reach_read2", 32'(k >= 100), 32'd0);
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    wait_end("abort", 20);
    check("abort_err", 32'(err_cnt), 32'd1);
    check("abort_writes", 32'(wr_cnt), 32'd1);
    check("abort_done_flag", 32'(done_cnt + flag_cnt), 32'd0);
    check("abort_im_offset", im_offset, 32'h40);
    check("abort_checksum", checksum, c_CKSUM ? exp_sum : 32'd0);
    end_checks("abort");

    // Abort and start together in IDLE: abort wins
    clr_stats(); ack_delay = 0;
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1; src_base = 32'h100; dst_base = 32'h700; length = 32'd2;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abstart_busy", 32'(busy_seen), 32'd0);
    check("abstart_err", 32'(err_cnt + wr_cnt + done_cnt), 32'd0);

    // Checksum wrap
    src_mem[10'h140] = 32'hFFFF_FFFF; src_mem[10'h141] = 32'h0000_0002;
    clr_stats();
    issue(32'h140, 32'h800, 32'd2, 1'b0, 2, 1'b0);
    wait_end("cksum", 50);
    check("cksum_value", checksum, c_CKSUM ? 32'h1 : 32'd0);
    end_checks("cksum");

    // Reset in the middle of a load
    clr_stats();
    issue(32'h100, 32'h900, 32'd4, 1'b1, 4, 1'b1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ctl", 32'({src_req, im_write, flag_imoffset, done, err}), 32'd0);
    check("midrst_src_addr", src_addr, 32'd0);
    check("midrst_im_offset", im_offset, 32'd0);
    check("midrst_checksum", checksum, 32'd0);
    exp_addr_q.delete(); exp_data_q.delete(); exp_off_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("postrst_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/im_load_ctrl.md
IM_LOAD_CTRL -- requirements
Module: im_load_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, data/address bus width; ADDR_WIDTH, 14, instruction-memory word-address width (depth 2**ADDR_WIDTH).
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
  clock  in  1  sole clock, all state on rising edge
  reset  in  1  asynchronous, active-low
  start  in  1  load request pulse, sampled in IDLE only
  abort  in  1  cancel load in progress
  commit_en  in  1  publish dst_base as IM offset on completion; sampled with start
  src_base  in  DATA_WIDTH  first source word address
  dst_base  in  DATA_WIDTH  first IM word address
  length  in  DATA_WIDTH  word count
  src_req  out  1  source read request
  src_addr  out  DATA_WIDTH  source read address
  src_ack  in  1  source data valid
  src_data  in  DATA_WIDTH  source read data
  im_write  out  1  IM write strobe
  im_write_addr  out  DATA_WIDTH  IM write address
  im_write_data  out  DATA_WIDTH  IM write data
  im_offset  out  DATA_WIDTH  IM offset value
  flag_imoffset  out  1  IM offset load strobe
  busy  out  1  state not IDLE
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle rejection/abort pulse
  checksum  out  DATA_WIDTH  running word sum

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, COMMIT, DONE.
REQ-004 IDLE: on start, SHALL latch src_base, dst_base, length, commit_en, clear index and checksum, go READ next edge.
REQ-005 start with length 0 SHALL go directly to DONE; no src_req, no im_write, no offset strobe.
REQ-006 start with dst_base+length > 2**ADDR_WIDTH (DATA_WIDTH+1-bit compare, no wrap) SHALL pulse err one cycle, remain IDLE, no writes.
REQ-007 READ: src_req=1, src_addr=src_base+index held stable until src_ack; on src_ack capture src_data, go WRITE.
REQ-008 WRITE: im_write=1 exactly one cycle, im_write_addr=dst_base+index, im_write_data=captured word; index+1; index==length-1 -> COMMIT if commit_en latched else DONE, otherwise READ.
REQ-009 Throughput SHALL be one word per 2 cycles with src_ack asserted combinationally in first READ cycle; latency start->done for N words = 2N+2 cycles (commit) or 2N+1.
REQ-010 COMMIT: flag_imoffset=1 one cycle, im_offset=dst_base; im_offset SHALL hold value afterwards.
REQ-011 DONE: done=1 one cycle, then IDLE.
REQ-012 start while busy SHALL be ignored.
REQ-013 abort in any non-IDLE state SHALL return to IDLE next edge, pulse err, suppress im_write/flag_imoffset/done that edge; abort and start together in IDLE: abort wins, nothing latched.
REQ-014 src_ack outside READ SHALL be ignored.
REQ-015 Address arithmetic SHALL wrap modulo 2**DATA_WIDTH on src side; index width DATA_WIDTH.

Reset
REQ-016 reset low SHALL force IDLE immediately; all outputs 0 (im_offset 0, checksum 0), including mid-transfer; partial IM contents not reverted.

Configuration
REQ-017 IM_LOAD_CKSUM_EN defined: checksum = modulo-2**DATA_WIDTH sum of words written since last accepted start, updated in WRITE, held after DONE.
REQ-018 IM_LOAD_CKSUM_EN undefined: checksum tied 0, no adder logic.

Structure
REQ-019 Package im_load_pkg SHALL hold FSM state enum and default width constants.
REQ-020 Checksum accumulator SHALL be sub-module im_load_cksum, instantiated only under IM_LOAD_CKSUM_EN.

Verification
REQ-021 start, src 0x100, dst 0x40, length 3, commit_en 1, src_ack immediate, data A,B,C -> im_write at 0x40..0x42 with A,B,C; flag_imoffset once, im_offset 0x40; done at cycle 8.
REQ-022 length 0 -> done one cycle after start, no im_write, no src_req.
REQ-023 dst 0x3FFE, length 3 (ADDR_WIDTH 14) -> err pulse, busy never set, no writes.
REQ-024 src_ack delayed 5 cycles -> src_req/src_addr stable throughout, single im_write per word.
REQ-025 abort during second READ of 4-word load -> one IM write only, err pulse, no done/flag_imoffset; reset low mid-load -> all outputs 0 immediately.
REQ-026 With IM_LOAD_CKSUM_EN, words 0xFFFFFFFF,0x2 -> checksum 0x1; without, checksum 0.
